// File: rtl/rgb2gray_pkg.sv
// Shared constants for the RGB-to-grayscale stream pipeline: conversion mode
// selectors, BT.601 luma weights and the datapath width helpers.
package rgb2gray_pkg;

    localparam int MODE_AVG     = 0;
    localparam int MODE_LUMA    = 1;

    // Weights sum to 2**WEIGHT_SHIFT so full-scale white maps to full scale.
    localparam int W_R          = 77;
    localparam int W_G          = 150;
    localparam int W_B          = 29;
    localparam int WEIGHT_SHIFT = 8;

    function automatic int sum_width(input int ch_w, input int mode);
        return (mode == MODE_LUMA) ? ch_w + 10 : ch_w + 2;
    endfunction

    function automatic int term_width(input int ch_w, input int mode);
        return (mode == MODE_LUMA) ? ch_w + 8 : ch_w;
    endfunction

endpackage

// File: rtl/rgb2gray_stream_pipe_ctrl.sv
// One pipeline stage's valid flag and ready/valid enable.
// A stage may advance when it is empty or its downstream is taking a beat.
module pipe_stage_ctrl (
    input  logic clk,
    input  logic reset,
    input  logic in_valid,
    input  logic out_ready,
    output logic valid,
    output logic en,
    output logic load
);

    assign en   = ~valid | out_ready;
    assign load = en & in_valid;

    // Valid follows the upstream offer whenever the stage is allowed to move.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
        end else if (en) begin
            valid <= in_valid;
        end
    end

endmodule

// File: rtl/rgb2gray_stream_pipe.sv
// Two-stage pipelined RGB-to-grayscale converter, Avalon-ST sink to source.
// Stage 1 holds per-channel terms, stage 2 holds the gray result.
// Optional packet statistics on the source side: define RGB2GRAY_PKT_STATS_EN.
module rgb2gray_stream_pipe
    import rgb2gray_pkg::*;
#(
    parameter int CH_W    = 8,
    parameter int MODE    = 0,
    parameter int RED_LSB = 1
) (
    input  logic              csi_clock_reset_clk,
    input  logic              csi_clock_reset_reset,
    input  logic [3*CH_W-1:0] asi_sink1_data,
    input  logic              asi_sink1_startofpacket,
    input  logic              asi_sink1_endofpacket,
    input  logic              asi_sink1_valid,
    output logic              asi_sink1_ready,
    input  logic              aso_source1_ready,
    output logic [CH_W-1:0]   aso_source1_data,
    output logic              aso_source1_startofpacket,
    output logic              aso_source1_endofpacket,
    output logic              aso_source1_valid
`ifdef RGB2GRAY_PKT_STATS_EN
    ,
    output logic [31:0]       pkt_len,
    output logic              pkt_len_valid,
    output logic              pkt_err
`endif
);

    localparam int TERM_W = term_width(CH_W, MODE);
    localparam int SUM_W  = sum_width(CH_W, MODE);

    logic              clk;
    logic              reset;
    logic [CH_W-1:0]   ch_r, ch_g, ch_b;
    logic [TERM_W-1:0] term_r, term_g, term_b;
    logic [TERM_W-1:0] t1_r, t1_g, t1_b;
    logic              sop1, eop1;
    logic [SUM_W-1:0]  sum1;
    logic [CH_W-1:0]   gray;
    logic              v1, v2, en1, en2, load1, load2;

    assign clk   = csi_clock_reset_clk;
    assign reset = csi_clock_reset_reset;

    generate
        if (RED_LSB != 0) begin : g_red_lsb
            assign ch_r = asi_sink1_data[CH_W-1:0];
            assign ch_g = asi_sink1_data[2*CH_W-1:CH_W];
            assign ch_b = asi_sink1_data[3*CH_W-1:2*CH_W];
        end else begin : g_blue_lsb
            assign ch_b = asi_sink1_data[CH_W-1:0];
            assign ch_g = asi_sink1_data[2*CH_W-1:CH_W];
            assign ch_r = asi_sink1_data[3*CH_W-1:2*CH_W];
        end

        if (MODE == MODE_LUMA) begin : g_luma
            // Weighted products; weights < 256 so each fits in CH_W+8 bits.
            always_comb begin
                term_r = TERM_W'(ch_r) * TERM_W'(W_R);
                term_g = TERM_W'(ch_g) * TERM_W'(W_G);
                term_b = TERM_W'(ch_b) * TERM_W'(W_B);
            end
            assign gray = CH_W'(sum1 >> WEIGHT_SHIFT);
        end else begin : g_avg
            // Plain channels; the divide by three happens in stage 2.
            always_comb begin
                term_r = ch_r;
                term_g = ch_g;
                term_b = ch_b;
            end
            assign gray = CH_W'(sum1 / SUM_W'(3));
        end
    endgenerate

    assign sum1 = SUM_W'(t1_r) + SUM_W'(t1_g) + SUM_W'(t1_b);

    pipe_stage_ctrl u_stage1 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (asi_sink1_valid),
        .out_ready (en2),
        .valid     (v1),
        .en        (en1),
        .load      (load1)
    );

    pipe_stage_ctrl u_stage2 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (v1),
        .out_ready (aso_source1_ready),
        .valid     (v2),
        .en        (en2),
        .load      (load2)
    );

    assign asi_sink1_ready   = en1;
    assign aso_source1_valid = v2;

    // Stage 1 captures channel terms and markers only on an accepted sink beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            t1_r <= '0;
            t1_g <= '0;
            t1_b <= '0;
            sop1 <= 1'b0;
            eop1 <= 1'b0;
        end else if (load1) begin
            t1_r <= term_r;
            t1_g <= term_g;
            t1_b <= term_b;
            sop1 <= asi_sink1_startofpacket;
            eop1 <= asi_sink1_endofpacket;
        end
    end

    // Stage 2 captures the finished gray value; held while the source stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            aso_source1_data          <= '0;
            aso_source1_startofpacket <= 1'b0;
            aso_source1_endofpacket   <= 1'b0;
        end else if (load2) begin
            aso_source1_data          <= gray;
            aso_source1_startofpacket <= sop1;
            aso_source1_endofpacket   <= eop1;
        end
    end

`ifdef RGB2GRAY_PKT_STATS_EN
    logic        out_xfer;
    logic        in_pkt;
    logic [31:0] beat_cnt;
    logic [31:0] cnt_next;

    assign out_xfer = aso_source1_valid & aso_source1_ready;

    // Running length of the current packet including the beat now leaving.
    always_comb begin
        cnt_next = aso_source1_startofpacket ? 32'd1 : beat_cnt + 32'd1;
    end

    // Source-side framing tracker: length report on EOP, sticky framing error.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_pkt        <= 1'b0;
            beat_cnt      <= '0;
            pkt_len       <= '0;
            pkt_len_valid <= 1'b0;
            pkt_err       <= 1'b0;
        end else begin
            pkt_len_valid <= out_xfer & aso_source1_endofpacket;
            if (out_xfer) begin
                beat_cnt <= cnt_next;
                if (aso_source1_startofpacket ? in_pkt : ~in_pkt) begin
                    pkt_err <= 1'b1;
                end
                if (aso_source1_endofpacket) begin
                    pkt_len <= cnt_next;
                    in_pkt  <= 1'b0;
                end else begin
                    in_pkt  <= 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_rgb2gray_stream_pipe.sv
// Bench for rgb2gray_stream_pipe: two instances share one stream
// (average / red-in-LSBs and luma / blue-in-LSBs), checked against a
// queue of accepted pixels and an arithmetic gray model.
module tb_rgb2gray_stream_pipe;

    typedef struct packed {
        logic [23:0] d;
        logic        sop;
        logic        eop;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] snk_data;
    logic        snk_sop, snk_eop, snk_valid;
    logic        snk_ready0, snk_ready1;
    logic        src_ready;
    logic [7:0]  src_data0, src_data1;
    logic        src_sop0, src_sop1, src_eop0, src_eop1, src_valid0, src_valid1;
`ifdef RGB2GRAY_PKT_STATS_EN
    logic [31:0] pkt_len0, pkt_len1;
    logic        pkt_len_valid0, pkt_len_valid1, pkt_err0, pkt_err1;
    int          n_pulse;
`endif

    int    n_checks = 0;
    int    n_fail   = 0;
    int    out_cnt  = 0;
    beat_t q[$];
    logic  prev_v, prev_r, prev_sop, prev_eop, have_prev;
    logic [7:0] prev_d0, prev_d1;

    always #5 clk = ~clk;

    rgb2gray_stream_pipe #(.CH_W(8), .MODE(0), .RED_LSB(1)) dut0 (
        .csi_clock_reset_clk       (clk),
        .csi_clock_reset_reset     (rst),
        .asi_sink1_data            (snk_data),
        .asi_sink1_startofpacket   (snk_sop),
        .asi_sink1_endofpacket     (snk_eop),
        .asi_sink1_valid           (snk_valid),
        .asi_sink1_ready           (snk_ready0),
        .aso_source1_ready         (src_ready),
        .aso_source1_data          (src_data0),
        .aso_source1_startofpacket (src_sop0),
        .aso_source1_endofpacket   (src_eop0),
        .aso_source1_valid         (src_valid0)
`ifdef RGB2GRAY_PKT_STATS_EN
        ,
        .pkt_len                   (pkt_len0),
        .pkt_len_valid             (pkt_len_valid0),
        .pkt_err                   (pkt_err0)
`endif
    );

    rgb2gray_stream_pipe #(.CH_W(8), .MODE(1), .RED_LSB(0)) dut1 (
        .csi_clock_reset_clk       (clk),
        .csi_clock_reset_reset     (rst),
        .asi_sink1_data            (snk_data),
        .asi_sink1_startofpacket   (snk_sop),
        .asi_sink1_endofpacket     (snk_eop),
        .asi_sink1_valid           (snk_valid),
        .asi_sink1_ready           (snk_ready1),
        .aso_source1_ready         (src_ready),
        .aso_source1_data          (src_data1),
        .aso_source1_startofpacket (src_sop1),
        .aso_source1_endofpacket   (src_eop1),
        .aso_source1_valid         (src_valid1)
`ifdef RGB2GRAY_PKT_STATS_EN
        ,
        .pkt_len                   (pkt_len1),
        .pkt_len_valid             (pkt_len_valid1),
        .pkt_err                   (pkt_err1)
`endif
    );

    // Gray value straight from the conversion formulas.
    function automatic logic [7:0] gray_model(input logic [23:0] d, input int mode,
                                              input int red_lsb);
        int lo, mid, hi, r, g, b;
        lo  = int'(d[7:0]);
        mid = int'(d[15:8]);
        hi  = int'(d[23:16]);
        r   = red_lsb ? lo : hi;
        g   = mid;
        b   = red_lsb ? hi : lo;
        if (mode == 0) return 8'((r + g + b) / 3);
        return 8'((77 * r + 150 * g + 29 * b) / 256);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus; acc reports whether the sink took the beat.
    task automatic drive(input logic v, input logic [23:0] d, input logic s, input logic e,
                         input logic r, output logic acc);
        snk_valid = v;
        snk_data  = d;
        snk_sop   = s;
        snk_eop   = e;
        src_ready = r;
        #1;
        acc = v & snk_ready0;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: record accepted pixels, check every output transfer and hold.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            have_prev = 1'b0;
        end else begin
            if (snk_valid && snk_ready0) q.push_back('{snk_data, snk_sop, snk_eop});
            check("ready_match", snk_ready1, snk_ready0);
            check("valid_match", src_valid1, src_valid0);
            if (have_prev && prev_v && !prev_r) begin
                check("hold_valid", src_valid0, 1);
                check("hold_data0", src_data0, prev_d0);
                check("hold_data1", src_data1, prev_d1);
                check("hold_sop", src_sop0, prev_sop);
                check("hold_eop", src_eop0, prev_eop);
            end
            if (src_valid0 && src_ready) begin
                beat_t b;
                out_cnt++;
                check("out_expected", (q.size() != 0), 1);
                if (q.size() != 0) begin
                    b = q.pop_front();
                    check("data_avg", src_data0, gray_model(b.d, 0, 1));
                    check("data_luma", src_data1, gray_model(b.d, 1, 0));
                    check("sop", {src_sop1, src_sop0}, {b.sop, b.sop});
                    check("eop", {src_eop1, src_eop0}, {b.eop, b.eop});
                end
            end
`ifdef RGB2GRAY_PKT_STATS_EN
            if (pkt_len_valid0) n_pulse++;
`endif
            prev_v    = src_valid0;
            prev_r    = src_ready;
            prev_d0   = src_data0;
            prev_d1   = src_data1;
            prev_sop  = src_sop0;
            prev_eop  = src_eop0;
            have_prev = 1'b1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic drain(input int max_cycles);
        logic acc;
        int guard = 0;
        while (q.size() != 0 && guard < max_cycles) begin
            drive(0, 24'd0, 0, 0, 1'($urandom_range(0, 1)), acc);
            guard++;
        end
        check("drain_empty", q.size(), 0);
        drive(0, 24'd0, 0, 0, 1, acc);
        drive(0, 24'd0, 0, 0, 1, acc);
    endtask

    task automatic do_reset();
        logic acc;
        rst = 1'b1;
        drive(0, 24'd0, 0, 0, 0, acc);
        drive(0, 24'd0, 0, 0, 0, acc);
        rst = 1'b0;
    endtask

    initial begin
        logic        acc;
        logic [23:0] pix;
        logic [7:0]  held;
        int          i, guard, cnt0;

        rst = 1'b1; snk_valid = 0; snk_data = 0; snk_sop = 0; snk_eop = 0; src_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_valid", src_valid0, 0);
        check("rst_data", src_data0, 0);
        check("rst_sop_eop", {src_sop0, src_eop0}, 0);
        check("rst_ready", snk_ready0, 1);

        // Average of (10,20,31) with red in the LSBs.
        drive(1, {8'd31, 8'd20, 8'd10}, 1, 1, 1, acc);
        check("t1_accept", acc, 1);
        drive(0, 24'd0, 0, 0, 1, acc);
        check("t1_valid", src_valid0, 1);
        check("t1_gray", src_data0, 20);
        check("t1_markers", {src_sop0, src_eop0}, 2'b11);
        drain(20);

        // Luma of primaries and white, blue in the LSBs for dut1.
        drive(1, {8'd255, 8'd0, 8'd0}, 1, 0, 1, acc);
        drive(1, {8'd0, 8'd255, 8'd0}, 0, 0, 1, acc);
        check("t2_red", src_data1, 76);
        drive(1, {8'd0, 8'd0, 8'd255}, 0, 0, 1, acc);
        check("t2_green", src_data1, 149);
        drive(1, {8'd255, 8'd255, 8'd255}, 0, 1, 1, acc);
        check("t2_blue", src_data1, 28);
        drive(0, 24'd0, 0, 0, 1, acc);
        check("t2_white", src_data1, 255);
        drain(20);

        // 64-pixel packet, random valid gaps and 50% output backpressure.
        cnt0 = out_cnt;
        i = 0; guard = 0;
        pix = 24'($urandom);
        while (i < 64 && guard < 2000) begin
            drive(1'($urandom_range(0, 9) < 7), pix, i == 0, i == 63,
                  1'($urandom_range(0, 1)), acc);
            if (acc) begin
                i++;
                pix = 24'($urandom);
            end
            guard++;
        end
        check("t3_sent", i, 64);
        drain(400);
        check("t3_out_count", out_cnt - cnt0, 64);

        // Fill the pipe with the output stalled, hold five cycles, release.
        i = 0; guard = 0;
        pix = 24'($urandom);
        while (i < 2 && guard < 10) begin
            drive(1, pix, i == 0, 0, 0, acc);
            if (acc) begin i++; pix = 24'($urandom); end
            guard++;
        end
        held = src_data0;
        for (int k = 0; k < 5; k++) begin
            drive(1, pix, 0, 0, 0, acc);
            check("t4_stall_ready", acc, 0);
            check("t4_stall_data", src_data0, held);
        end
        for (int k = 0; k < 6; k++) begin
            drive(1, pix, 0, k == 5, 1, acc);
            check("t4_resume_accept", acc, 1);
            check("t4_resume_valid", src_valid0, 1);
            pix = 24'($urandom);
        end
        drain(20);

        // Reset with two beats in flight.
        drive(1, 24'($urandom), 1, 0, 0, acc);
        drive(1, 24'($urandom), 0, 0, 0, acc);
        check("t5_full", src_valid0, 1);
        rst = 1'b1;
        drive(0, 24'd0, 0, 0, 0, acc);
        check("t5_valid_cleared", src_valid0, 0);
        check("t5_ready", snk_ready0, 1);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(0, 24'd0, 0, 0, 1, acc);
            check("t5_no_stale", src_valid0, 0);
        end

`ifdef RGB2GRAY_PKT_STATS_EN
        n_pulse = 0;
        for (int k = 0; k < 10; k++) drive(1, 24'($urandom), k == 0, k == 9, 1, acc);
        drain(20);
        check("t6_len", pkt_len0, 10);
        check("t6_pulses", n_pulse, 1);
        check("t6_no_err", pkt_err0, 0);
        drive(1, 24'($urandom), 1, 0, 1, acc);
        drive(1, 24'($urandom), 1, 0, 1, acc);
        drive(1, 24'($urandom), 0, 1, 1, acc);
        drain(20);
        check("t6_err", pkt_err0, 1);
        drive(1, 24'($urandom), 1, 1, 1, acc);
        drain(20);
        check("t6_err_sticky", pkt_err0, 1);
        check("t6_single_len", pkt_len0, 1);
        do_reset();
        check("t6_err_reset", pkt_err0, 0);
        check("t6_len_reset", pkt_len0, 0);
`else
        do_reset();
`endif
        check("final_idle", src_valid0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
